// File: rtl/key_move_scheduler_if.sv
// ---------------------------------------------------------------------------
// key_move_scheduler_if
//   Move command handshake between the key scheduler and the game core.
//   KMS_move_valid  scheduler -> core : a move command is present
//   KMS_move_dir    scheduler -> core : 0 = up, 1 = down, 2 = left, 3 = right
//   KMS_move_ready  core -> scheduler : core can accept a move
//   A move transfers on the first clock edge where valid and ready are both
//   high.
// ---------------------------------------------------------------------------
interface key_move_scheduler_if;
  logic       KMS_move_valid;
  logic       KMS_move_ready;
  logic [1:0] KMS_move_dir;

  modport master (
    output KMS_move_valid,
    output KMS_move_dir,
    input  KMS_move_ready
  );

  modport slave (
    input  KMS_move_valid,
    input  KMS_move_dir,
    output KMS_move_ready
  );
endinterface

// File: rtl/key_move_scheduler.sv
// ---------------------------------------------------------------------------
// key_move_scheduler
//   Debounces four raw direction keys, latches one pending press per
//   direction, round-robin arbitrates among pending presses and issues one
//   move at a time over a valid/ready handshake, followed by an optional
//   forced idle gap.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a key level change (>= 2)
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   MIN_GAP          idle cycles forced after each accepted move (0 = none)
//   GAP_W            gap counter width
//
// Ports
//   KMS_clk          system clock
//   KMS_rst          synchronous active-high reset
//   KMS_key_*        raw asynchronous key levels, high = pressed
//   KMS_enable       high = accept and issue moves
//   mv               move handshake (master side)
//   KMS_key_state    debounced levels {right, left, down, up}
//   KMS_overrun      one-cycle pulse: press on an already pending direction
// ---------------------------------------------------------------------------
module key_move_scheduler #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19,
  parameter int MIN_GAP         = 0,
  parameter int GAP_W           = 16
) (
  input  logic                 KMS_clk,
  input  logic                 KMS_rst,
  input  logic                 KMS_key_up,
  input  logic                 KMS_key_down,
  input  logic                 KMS_key_left,
  input  logic                 KMS_key_right,
  input  logic                 KMS_enable,
  key_move_scheduler_if.master mv,
  output logic [3:0]           KMS_key_state,
  output logic                 KMS_overrun
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Bit index equals the direction code.
  logic [3:0] w_key_raw;
  logic [3:0] w_deb;
  logic [3:0] w_press;
  logic [3:0] r_deb_d;

  assign w_key_raw = {KMS_key_right, KMS_key_left, KMS_key_down, KMS_key_up};

  // -------------------------------------------------------------------------
  // Per-key synchronizer and debounce
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      logic             r_sync1;
      logic             r_sync2;
      logic             r_deb;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge KMS_clk) begin
        if (KMS_rst) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_deb   <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_key_raw[gi];
          r_sync2 <= r_sync1;
          // Any return to the accepted level restarts the stability count,
          // so a glitch shorter than DEBOUNCE_CYCLES never reaches r_deb.
          if (r_sync2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      end

      assign w_deb[gi] = r_deb;
    end
  endgenerate

  always_ff @(posedge KMS_clk) begin
    if (KMS_rst) begin
      r_deb_d <= '0;
    end else begin
      r_deb_d <= w_deb;
    end
  end

  assign w_press = w_deb & ~r_deb_d;

  // -------------------------------------------------------------------------
  // Pending presses, round-robin search, move FSM
  // -------------------------------------------------------------------------
  state_t           r_state, w_state_next;
  logic [3:0]       r_pending, w_pending_next;
  logic [1:0]       r_ptr, w_ptr_next;
  logic             r_valid, w_valid_next;
  logic [1:0]       r_dir, w_dir_next;
  logic [GAP_W-1:0] r_gap, w_gap_next;
  logic             r_overrun;
  logic [3:0]       w_clear;
  logic             w_found;
  logic [1:0]       w_grant_idx;

  // First pending bit at or after the pointer, wrapping up->down->left->right.
  always_comb begin
    logic [1:0] v_idx;
    v_idx       = r_ptr;
    w_found     = 1'b0;
    w_grant_idx = r_ptr;
    for (int k = 0; k < 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && r_pending[v_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = v_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_dir_next   = r_dir;
    w_ptr_next   = r_ptr;
    w_gap_next   = r_gap;
    w_clear      = 4'b0000;

    case (r_state)
      S_IDLE: begin
        if (KMS_enable && w_found) begin
          w_valid_next = 1'b1;
          w_dir_next   = w_grant_idx;
          w_ptr_next   = w_grant_idx + 2'd1;
          w_clear      = 4'b0001 << w_grant_idx;
          w_state_next = S_ISSUE;
        end
      end
      // Enable is deliberately ignored here: an offered move is never withdrawn.
      S_ISSUE: begin
        if (r_valid && mv.KMS_move_ready) begin
          w_valid_next = 1'b0;
          w_gap_next   = '0;
          w_state_next = (MIN_GAP > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_gap_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_gap_next = r_gap + GAP_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_valid_next = 1'b0;
      end
    endcase

    // A press landing on the grant cycle re-arms the bit (set wins).
    if (KMS_enable) begin
      w_pending_next = (r_pending & ~w_clear) | w_press;
    end else begin
      w_pending_next = 4'b0000;
    end
  end

  always_ff @(posedge KMS_clk) begin
    if (KMS_rst) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_ptr     <= 2'd0;
      r_valid   <= 1'b0;
      r_dir     <= 2'd0;
      r_gap     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_ptr     <= w_ptr_next;
      r_valid   <= w_valid_next;
      r_dir     <= w_dir_next;
      r_gap     <= w_gap_next;
      r_overrun <= |(w_press & r_pending);
    end
  end

  assign mv.KMS_move_valid = r_valid;
  assign mv.KMS_move_dir   = r_dir;
  assign KMS_key_state     = w_deb;
  assign KMS_overrun       = r_overrun;

endmodule

// File: tb/tb_key_move_scheduler.sv
module tb_key_move_scheduler;
  localparam int DEB = 4;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       srst;
  logic       key_up, key_down, key_left, key_right;
  logic       enable;
  logic [3:0] key_state;
  logic       overrun;

  key_move_scheduler_if mv_if ();

  always #5 clk = ~clk;

  key_move_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .MIN_GAP        (GAP),
    .GAP_W          (16)
  ) dut (
    .KMS_clk      (clk),
    .KMS_rst      (srst),
    .KMS_key_up   (key_up),
    .KMS_key_down (key_down),
    .KMS_key_left (key_left),
    .KMS_key_right(key_right),
    .KMS_enable   (enable),
    .mv           (mv_if),
    .KMS_key_state(key_state),
    .KMS_overrun  (overrun)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] exp_q[$];
  bit         gap_check_en = 1'b0;
  int         overrun_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each
  // transfer, checks stall stability and back-to-back gap length.
  logic       prev_valid = 1'b0;
  logic       prev_xfer  = 1'b0;
  logic       prev_srst  = 1'b1;
  logic [1:0] prev_dir   = 2'd0;
  int         low_cnt    = 0;
  bit         after_xfer = 1'b0;

  always @(negedge clk) begin
    logic xfer;
    xfer = mv_if.KMS_move_valid && mv_if.KMS_move_ready && !srst;
    if (overrun) overrun_cnt++;
    if (prev_valid && !prev_xfer && !prev_srst && !srst) begin
      check("stall_valid", mv_if.KMS_move_valid, 1);
      check("stall_dir", mv_if.KMS_move_dir, prev_dir);
    end
    if (mv_if.KMS_move_valid && !prev_valid) begin
      if (gap_check_en && after_xfer && low_cnt < 10) check("gap_len", low_cnt, 3);
      after_xfer = 1'b0;
    end
    if (srst) after_xfer = 1'b0;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_move: got dir %0d, expected no move (t=%0t)", mv_if.KMS_move_dir, $time);
      end else begin
        check("move_dir", mv_if.KMS_move_dir, exp_q.pop_front());
      end
      low_cnt    = 0;
      after_xfer = 1'b1;
    end else if (!mv_if.KMS_move_valid) begin
      low_cnt++;
    end
    prev_valid = mv_if.KMS_move_valid;
    prev_xfer  = xfer;
    prev_srst  = srst;
    prev_dir   = mv_if.KMS_move_dir;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    srst = 1'b1;
    {key_up, key_down, key_left, key_right} = 4'b0000;
    enable = 1'b1;
    mv_if.KMS_move_ready = 1'b1;
    step(3);
    check("rst_valid", mv_if.KMS_move_valid, 0);
    check("rst_dir", mv_if.KMS_move_dir, 0);
    check("rst_key_state", key_state, 0);
    check("rst_overrun", overrun, 0);
    srst = 1'b0;
    step(2);

    // 1. Single press: valid after edge 7, transfer at edge 8
    exp_q.push_back(2'd0);
    key_up = 1'b1;
    step(7);
    check("t1_valid_early", mv_if.KMS_move_valid, 0);
    step(1);
    check("t1_valid", mv_if.KMS_move_valid, 1);
    check("t1_dir", mv_if.KMS_move_dir, 0);
    check("t1_key_state", key_state, 4'b0001);
    step(1);
    check("t1_valid_after_xfer", mv_if.KMS_move_valid, 0);
    step(20);
    check("t1_key_held", key_state, 4'b0001);
    key_up = 1'b0;
    step(10);
    check("t1_key_released", key_state, 4'b0000);

    // 2. Glitch: 3-cycle pulse on down must never be accepted
    key_down = 1'b1;
    step(3);
    key_down = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("t2_key_state", key_state, 0);
      check("t2_valid", mv_if.KMS_move_valid, 0);
    end

    // 3. Simultaneous up/left/right, twice, pointer starting at up
    srst = 1'b1;
    step(2);
    srst = 1'b0;
    gap_check_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      {key_up, key_left, key_right} = 3'b111;
      step(7);
      check("t3_key_state", key_state, 4'b1101);
      step(25);
      {key_up, key_left, key_right} = 3'b000;
      step(15);
    end

    // 4. Stall with ready low, re-press of a pending direction
    mv_if.KMS_move_ready = 1'b0;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    key_up = 1'b1;
    step(8);
    check("t4_valid", mv_if.KMS_move_valid, 1);
    check("t4_dir", mv_if.KMS_move_dir, 0);
    key_down = 1'b1;
    step(8);
    key_down = 1'b0;
    step(8);
    check("t4_no_overrun_yet", overrun_cnt, 0);
    key_down = 1'b1;
    step(8);
    check("t4_overrun_once", overrun_cnt, 1);
    mv_if.KMS_move_ready = 1'b1;
    step(15);
    key_down = 1'b0;
    key_up   = 1'b0;
    step(15);
    check("t4_overrun_total", overrun_cnt, 1);

    // 5a. Enable dropped during ISSUE: left completes, pending right discarded
    mv_if.KMS_move_ready = 1'b0;
    exp_q.push_back(2'd2);
    key_left  = 1'b1;
    key_right = 1'b1;
    step(8);
    check("t5a_valid", mv_if.KMS_move_valid, 1);
    check("t5a_dir", mv_if.KMS_move_dir, 2);
    enable = 1'b0;
    step(3);
    mv_if.KMS_move_ready = 1'b1;
    step(5);
    enable = 1'b1;
    step(20);
    key_left  = 1'b0;
    key_right = 1'b0;
    step(15);

    // 5b. Reset mid-ISSUE with up+left held through reset
    mv_if.KMS_move_ready = 1'b0;
    key_up   = 1'b1;
    key_left = 1'b1;
    step(8);
    check("t5b_valid_pre", mv_if.KMS_move_valid, 1);
    check("t5b_dir_pre", mv_if.KMS_move_dir, 0);
    srst = 1'b1;
    step(1);
    check("t5b_rst_valid", mv_if.KMS_move_valid, 0);
    check("t5b_rst_dir", mv_if.KMS_move_dir, 0);
    check("t5b_rst_key_state", key_state, 0);
    srst = 1'b0;
    mv_if.KMS_move_ready = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd2);
    step(7);
    check("t5b_valid_early", mv_if.KMS_move_valid, 0);
    step(1);
    check("t5b_valid", mv_if.KMS_move_valid, 1);
    check("t5b_dir", mv_if.KMS_move_dir, 0);
    step(20);
    key_up   = 1'b0;
    key_left = 1'b0;
    step(15);

    check("sb_empty", exp_q.size(), 0);
    check("overrun_final", overrun_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_move_scheduler.md
# key_move_scheduler

Sits between the four raw direction touch keys and the game core. Debounces each key, latches one pending press per direction, and round-robin arbitrates simultaneous presses. Issues exactly one move at a time to the core over a valid/ready handshake, then enforces a minimum gap before the next move. Fixes the missing debounce and the lost or overlapping pulses of direct edge-detect wiring.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a key level change (20 ms at 25 MHz); minimum 2.
- CNT_W, 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- MIN_GAP, 0: idle cycles forced after each accepted move (0 = none).
- GAP_W, 16: gap counter width.

- KMS_clk  input  1  system clock, 25 MHz.
- KMS_rst  input  1  synchronous, active-high reset.
- KMS_key_up / KMS_key_down / KMS_key_left / KMS_key_right  input  1 each  raw asynchronous key levels, high = pressed.
- KMS_enable  input  1  high = accept and issue moves.
- KMS_move_ready  input  1  core can accept a move.
- KMS_move_valid  output  1  move command present.
- KMS_move_dir  output  2  0 = up, 1 = down, 2 = left, 3 = right.
- KMS_key_state  output  4  debounced levels, bit order {right, left, down, up}.
- KMS_overrun  output  1  one-cycle pulse: a press arrived for a direction already pending.

## Operation
- **Per-key front end**
  - 2-flop synchronizer: sync1 then sync2.
  - Debounce counter:
    - sync2 == deb: counter cleared to 0.
    - sync2 != deb and counter == DEBOUNCE_CYCLES-1: deb <= sync2, counter cleared.
    - Otherwise: counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES never changes deb.
- **Press event:** deb rising edge (deb & ~deb_d). Release is ignored except for KMS_key_state.
- **Pending bits:** pending[i] is set by press event i and cleared when i is granted.
  - Set and clear in the same cycle: set wins.
  - Press on an already-set pending bit: the press merges and KMS_overrun pulses.
- **Round-robin pointer:** reset value = up. After granting i, pointer = (i+1) mod 4. Search starts at the pointer and proceeds in order up, down, left, right, wrapping.
- **FSM**
  - IDLE: if KMS_enable and any pending bit, grant per round-robin, load KMS_move_dir, assert KMS_move_valid, clear the granted pending bit, go to ISSUE.
  - ISSUE: hold valid and dir stable until an edge where valid & ready.
    - At that edge, the transfer occurs and valid drops.
    - Next state is GAP if MIN_GAP > 0, else IDLE.
  - GAP: count MIN_GAP cycles with valid low, then go to IDLE.
- **KMS_enable low**
  - Pending bits are cleared and held clear.
  - No new grants.
  - An ISSUE already in progress completes normally; dropping enable never withdraws valid.
  - Debounce and KMS_key_state keep running.
- **Reset (including mid-handshake)**
  - Output values: KMS_move_valid 0, KMS_move_dir 0, KMS_key_state 0, KMS_overrun 0.
  - Internal state: pending 0, counters 0, sync and deb 0, pointer = up, FSM = IDLE.
  - Any in-flight move is abandoned.
  - A key held through reset produces a press event once it is debounced high after reset.

## Timing
- **Press-to-valid latency:**
  - Raw key first sampled high at edge 0 and held.
  - deb rises at edge DEBOUNCE_CYCLES+1; pending sets at edge DEBOUNCE_CYCLES+2.
  - KMS_move_valid is high after edge DEBOUNCE_CYCLES+3 (FSM idle, enable high).
- **Ready behaviour:** ready may be high before valid. Transfer happens on the first edge where both are high. valid never depends combinationally on ready.
- **Back-to-back moves, MIN_GAP = 0:** valid low for exactly 1 cycle (IDLE) between consecutive moves.
- **Back-to-back moves, MIN_GAP = N:** valid low for N+1 cycles.
- **Overrun pulse:** asserted the cycle after the offending press event.
- **Key state:** KMS_key_state[i] = deb[i], registered, with no extra delay.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, MIN_GAP = 2, ready tied high unless stated.
1. Single press: up high from edge 0 -> valid=1, dir=0 after edge 7; transfer at edge 8; valid low for 3 cycles; no further moves.
2. Glitch rejection: down pulsed high for 3 cycles, then low -> KMS_key_state stays 0, valid never asserts.
3. Simultaneous presses: up, left and right rise at the same edge, repeated twice -> first round dir sequence 0, 2, 3; second round starts after the pointer at 0 and again yields 0, 2, 3; each move separated by 3 low cycles.
4. Handshake stall and overrun:
   - Ready held low 10 cycles after valid -> dir stays constant and valid stays high throughout.
   - Re-pressing the same direction while it is pending -> KMS_overrun pulses once and exactly one extra move follows.
5. Enable and reset:
   - Enable dropped during ISSUE -> the current move completes and pending is discarded.
   - KMS_rst asserted mid-ISSUE -> valid 0 after that edge, pointer returns to up, and a key held through reset issues one move DEBOUNCE_CYCLES+3 edges after reset release.
